// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bus of fifo_wr_arbiter; master is the arbiter, slave is its environment.
// FIFO_WR_ARBITER_LOCK_EN adds the per-requester lock input.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          fifo_full;
    logic                          fifo_almost_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
`ifdef FIFO_WR_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]            lock;

    modport master (
        input  req, req_data, fifo_full, fifo_almost_full, lock,
        output req_ack, grant, fifo_wr_en, fifo_wr_data
    );
    modport slave (
        output req, req_data, fifo_full, fifo_almost_full, lock,
        input  req_ack, grant, fifo_wr_en, fifo_wr_data
    );
`else
    modport master (
        input  req, req_data, fifo_full, fifo_almost_full,
        output req_ack, grant, fifo_wr_en, fifo_wr_data
    );
    modport slave (
        output req, req_data, fifo_full, fifo_almost_full,
        input  req_ack, grant, fifo_wr_en, fifo_wr_data
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters into one sync-FIFO write port with burst limiting.
// Optional FIFO_WR_ARBITER_LOCK_EN: a held lock bit suspends the burst limit for the current owner.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.master     bus
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT1_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

    state_t                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      r_last_owner;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_req_any;
    logic                  w_owner_req;
    logic                  w_owner_lock;
    logic                  w_accept;
    logic                  w_burst_hit;
    logic                  w_exit;
    logic                  w_next_found;
    logic [IDX_W-1:0]      w_next_owner;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic [CNT1_W-1:0]     w_cnt_inc;

    assign w_req_any   = |bus.req;
    assign w_owner_req = |(bus.req & r_grant);
`ifdef FIFO_WR_ARBITER_LOCK_EN
    assign w_owner_lock = |(bus.lock & r_grant);
`else
    assign w_owner_lock = 1'b0;
`endif

    // The almost_full term covers the write already in flight from last cycle.
    assign w_accept = rst_n & (r_state == XFER) & w_owner_req & ~bus.fifo_full
                    & ~(r_wr_en & bus.fifo_almost_full);

    assign w_cnt_inc   = {1'b0, r_burst_cnt} + CNT1_W'(1);
    assign w_burst_hit = w_accept & (w_cnt_inc >= CNT1_W'(BURST_MAX)) & ~w_owner_lock;
    assign w_exit      = ~w_owner_req | w_burst_hit;

    assign bus.req_ack      = w_accept ? r_grant : '0;
    assign bus.grant        = r_grant;
    assign bus.fifo_wr_en   = r_wr_en;
    assign bus.fifo_wr_data = r_wr_data;

    // First requesting index after the previous owner, wrapping around.
    always_comb begin
        w_next_found = 1'b0;
        w_next_owner = r_last_owner;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_next_found && bus.req[IDX_W'((32'(r_last_owner) + k) % NUM_REQ)]) begin
                w_next_found = 1'b1;
                w_next_owner = IDX_W'((32'(r_last_owner) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data <= w_owner_data;
            end
            case (r_state)
                IDLE: begin
                    r_grant <= '0;
                    if (w_req_any) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (w_next_found) begin
                        r_owner     <= w_next_owner;
                        r_grant     <= NUM_REQ'(1) << w_next_owner;
                        r_burst_cnt <= '0;
                        r_state     <= XFER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                XFER: begin
                    // Saturate so a long locked burst cannot wrap the counter.
                    if (w_accept && (w_cnt_inc <= CNT1_W'(BURST_MAX))) begin
                        r_burst_cnt <= CNT_W'(w_cnt_inc);
                    end
                    if (w_exit) begin
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                        r_state      <= w_req_any ? ARB : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester payload and of fifo_wr_data.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, 2 to 8.
REQ-003 Parameter BURST_MAX, default 4: maximum consecutive accepted writes per grant before re-arbitration, 1 to 15.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 req  input  NUM_REQ  per-requester write request; bit i is held with its data until the matching ack.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ack  output  NUM_REQ  combinational; bit i high means requester i's word is accepted this cycle.
REQ-009 grant  output  NUM_REQ  registered one-hot current owner, or all zero.
REQ-010 fifo_full  input  1  full flag from the downstream sync FIFO.
REQ-011 fifo_almost_full  input  1  high when FIFO count is at least FIFO depth minus 1.
REQ-012 fifo_wr_en  output  1  registered write strobe to the FIFO.
REQ-013 fifo_wr_data  output  DATA_WIDTH  registered write data to the FIFO.

Function
REQ-014 The FSM SHALL have states IDLE, ARB and XFER.
REQ-015 IDLE: grant is zero; any req bit high moves the FSM to ARB on the next edge.
REQ-016 ARB (one cycle): the owner is the first requester with req high, searching from last_owner+1 modulo NUM_REQ; grant is loaded one-hot; burst_cnt is cleared; next state is XFER; if no req is high, next state is IDLE.
REQ-017 XFER accept condition: req_ack[owner] = grant[owner] & req[owner] & ~fifo_full & ~(fifo_wr_en & fifo_almost_full); all other ack bits are 0.
REQ-018 On accept: fifo_wr_en is 1 and fifo_wr_data is req_data[owner] on the next edge (latency 1 cycle); burst_cnt increments.
REQ-019 With no accept in a cycle, fifo_wr_en is 0 on the next edge and fifo_wr_data holds its value.
REQ-020 XFER exits when req[owner] is low, or when an accept brings burst_cnt to BURST_MAX.
REQ-021 On exit: last_owner takes the owner index and grant clears; next state is ARB if any req is high, else IDLE.
REQ-022 fifo_full held high in XFER keeps the grant and suspends accepts; burst_cnt is unchanged; no timeout.
REQ-023 A requester dropping req without ack loses the grant; the arbiter does not write its data.
REQ-024 Simultaneous requests are served strictly round-robin; no requester waits more than NUM_REQ grants.
REQ-025 A lone requester with req held continuously gets back-to-back grants, with one ARB bubble every BURST_MAX writes.
REQ-026 At most one FIFO write per cycle.
REQ-027 No write is issued while fifo_full is high, including the in-flight case covered by the almost_full guard.

Reset
REQ-028 When rst_n is low at a rising edge: FSM goes to IDLE; grant, fifo_wr_en, fifo_wr_data and burst_cnt go to 0; last_owner goes to NUM_REQ-1, so requester 0 has first priority.
REQ-029 req_ack SHALL be 0 throughout reset.
REQ-030 Reset asserted during XFER abandons the burst; a write registered on that edge is suppressed.

Configuration
REQ-031 Macro FIFO_WR_ARBITER_LOCK_EN, when defined, adds input lock (NUM_REQ bits).
REQ-032 With the macro defined, while lock[owner] is high in XFER the BURST_MAX exit is disabled; the grant is released only when req[owner] or lock[owner] falls.
REQ-033 Without the macro, the lock port is absent and the BURST_MAX exit always applies.

Verification
REQ-034 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, fifo_wr_en=0, req_ack=0, fifo_wr_data=0.
REQ-035 Round-robin: req=4'b1111 held, each requester sends 1 word then drops req -> grant order 0,1,2,3 and FIFO receives those payloads in that order.
REQ-036 Burst limit: req0 held with 10 words, BURST_MAX=4, req1 also high -> writes are 4 from req0, then req1's words, then req0 resumes.
REQ-037 Full stall: fifo_full=1 for 5 cycles mid-burst -> req_ack=0 and fifo_wr_en=0 for those cycles, grant unchanged; transfer resumes the cycle after full drops.
REQ-038 Almost-full guard: fifo_wr_en=1 and fifo_almost_full=1 -> no accept that cycle; fifo_full is never high in the same cycle as fifo_wr_en.
REQ-039 With FIFO_WR_ARBITER_LOCK_EN defined, lock0=1 and 8 words from req0 with req1 pending -> all 8 written before grant moves to requester 1.
